pulse_period_meter: RTL and testbench
=====================================

# pulse_period_meter

Receive-side companion to the periodic pulse generator. It measures the interval between successive pulses on one input in `sys_clk` cycles and classifies each interval as a 1 s, 2 s or 4 s tick within a tolerance window. It also flags out-of-window intervals and lost pulses (timeout). It sits downstream of any tick source and checks timebase integrity on the board and in simulation.

## Interface
- `CLK_HZ`, default 50_000_000: `sys_clk` frequency. Sets the 1 s target; the 2 s and 4 s targets are 2·`CLK_HZ` and 4·`CLK_HZ`.
- `TOL_CYCLES`, default 50_000: allowed ±deviation from each target. Must be < `CLK_HZ`/2.
- `TIMEOUT_CYCLES`, default 250_000_000: interval with no pulse after which `timeout` is raised. Must be > 4·`CLK_HZ` + `TOL_CYCLES` and < 2^32.
- `sys_clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `pulse_in` in 1: tick input, synchronous to `sys_clk`. Only its rising edge is significant.
- `meas_valid` out 1: one-cycle strobe; a new measurement is on the outputs.
- `meas_cycles` out 32: last measured interval, in cycles.
- `class_1s` / `class_2s` / `class_4s` out 1: classification of the last measurement. Level outputs, held until the next measurement.
- `class_err` out 1: last measurement fell outside all three windows. Level output.
- `timeout` out 1: level output; no edge seen for `TIMEOUT_CYCLES`.
- `good_count` out 16: number of in-window measurements. Active only with the stats feature.
- `err_count` out 16: number of `class_err` measurements plus timeouts. Active only with the stats feature.

## Operation
- Edge detect: `edge` = `pulse_in` & ~`pulse_d`, where `pulse_d` is `pulse_in` registered (reset value 0). A level held high yields one event.
- State IDLE (reset state), waiting for the first edge:
  - on `edge`: `cnt` <= 0, go to MEAS. No measurement is emitted.
- State MEAS:
  - `cnt` increments each cycle.
  - On `edge`:
    - `meas_cycles` <= `cnt`+1 and `meas_valid` <= 1.
    - Classification outputs update. Exactly one of `class_1s`/`class_2s`/`class_4s`/`class_err` is 1.
    - `cnt` <= 0; stay in MEAS.
  - Else, if `cnt` == `TIMEOUT_CYCLES`−1: `timeout` <= 1, go to TOUT, and `cnt` holds.
- State TOUT:
  - on `edge`: `timeout` <= 0, `cnt` <= 0, go to MEAS. No measurement is emitted, because the interval is invalid.
- Classification is an unsigned range check `target`−`TOL_CYCLES` ≤ N ≤ `target`+`TOL_CYCLES`, with N = `cnt`+1.
  - All comparisons are 32-bit unsigned.
  - The windows are disjoint by the parameter constraints.
- Reset values: all outputs 0; `cnt` = 0; state IDLE.
- Reset mid-operation discards any partial interval. The next edge is treated as the first edge.
- An `edge` in the same cycle that `cnt` reaches `TIMEOUT_CYCLES`−1: the edge wins. The measurement is emitted (class_err) and there is no timeout.

## Timing
- An edge at interval N after the previous edge gives `meas_cycles` = N.
- `meas_valid`, `meas_cycles` and the class outputs are registered. They update in the cycle after the one in which `pulse_in` is first sampled high.
- `meas_valid` lasts exactly 1 cycle. There is no handshake; the consumer must sample on the strobe.
- `timeout` rises exactly `TIMEOUT_CYCLES` cycles after the last edge's `cnt` clear. It falls one cycle after the next edge.

## Configuration
- `PULSE_PERIOD_METER_STATS_EN` defined: `good_count` and `err_count` are saturating 16-bit counters, cleared by `rst`.
  - `good_count` increments on each in-window `meas_valid`.
  - `err_count` increments on each `class_err` measurement and on each entry into TOUT.
- Macro undefined: both ports are present and tied to 0, and no counter logic is built.

## Structure
- Package `pulse_meter_pkg`:
  - state enum {IDLE, MEAS, TOUT};
  - `CNT_W` = 32;
  - stats width 16.
- Sub-module `pulse_window_cmp`: purely combinational.
  - Inputs: value, target, tolerance.
  - Output: in-window bit.
  - Instantiated three times, once per target.

## Test plan
All directed tests use `CLK_HZ`=100, `TOL_CYCLES`=2, `TIMEOUT_CYCLES`=500.
- Reset, then a single pulse: all outputs stay 0, no `meas_valid`.
- Pulses 100 cycles apart: `meas_valid` one cycle per pulse after the first, `meas_cycles`=100, `class_1s`=1.
- Intervals 202 then 203: first gives `class_2s`=1; second gives `class_err`=1 with `meas_cycles`=203.
- Pulse, then silence for 500 cycles: `timeout`=1 at cycle 500.
  - Next pulse: no `meas_valid` and `timeout`→0.
  - A further pulse 400 cycles later: `class_4s`=1.
- `pulse_in` held high for 10 cycles at 100-cycle spacing of rising edges: one `meas_valid` per edge, `meas_cycles`=100.
- `rst` asserted 50 cycles into an interval: all outputs 0. The following edge produces no `meas_valid`; the edge after it, 100 cycles later, yields `meas_cycles`=100.
  - With `PULSE_PERIOD_METER_STATS_EN`, the counts are checked after the error and timeout scenarios above.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared types and widths for the pulse period meter.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    TOUT = 2'd2
  } meter_state_e;

  localparam int CNT_W  = 32;
  localparam int STAT_W = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pulse_window_cmp.sv
// Combinational check that value lies in [target - tol, target + tol], unsigned.
module pulse_window_cmp
  import pulse_meter_pkg::*;
(
  input  logic [CNT_W-1:0] value,
  input  logic [CNT_W-1:0] target,
  input  logic [CNT_W-1:0] tol,
  output logic             in_win
);

  logic [CNT_W-1:0] lo;
  logic [CNT_W-1:0] hi;

  assign lo     = target - tol;
  assign hi     = target + tol;
  assign in_win = (value >= lo) && (value <= hi);

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the interval between rising edges of pulse_in and classifies it as 1 s/2 s/4 s.
// Optional saturating good/error statistics are built when PULSE_PERIOD_METER_STATS_EN is defined.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned TOL_CYCLES     = 50_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  meas_cycles,
  output logic              class_1s,
  output logic              class_2s,
  output logic              class_4s,
  output logic              class_err,
  output logic              timeout,
  output logic [STAT_W-1:0] good_count,
  output logic [STAT_W-1:0] err_count,
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] TGT_1S  = CNT_W'(CLK_HZ);
  localparam logic [CNT_W-1:0] TGT_2S  = CNT_W'(2 * CLK_HZ);
  localparam logic [CNT_W-1:0] TGT_4S  = CNT_W'(4 * CLK_HZ);
  localparam logic [CNT_W-1:0] TOL     = CNT_W'(TOL_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_d_q;
  logic             meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0] meas_cycles_q, meas_cycles_d;
  logic             class_1s_q, class_1s_d;
  logic             class_2s_q, class_2s_d;
  logic             class_4s_q, class_4s_d;
  logic             class_err_q, class_err_d;
  logic             timeout_q, timeout_d;

  logic             rise_w;
  logic [CNT_W-1:0] n_val;
  logic             in_1s, in_2s, in_4s;

  assign rise_w = pulse_in & ~pulse_d_q;
  assign n_val  = cnt_q + 1'b1;

  pulse_window_cmp u_win_1s (.value(n_val), .target(TGT_1S), .tol(TOL), .in_win(in_1s));
  pulse_window_cmp u_win_2s (.value(n_val), .target(TGT_2S), .tol(TOL), .in_win(in_2s));
  pulse_window_cmp u_win_4s (.value(n_val), .target(TGT_4S), .tol(TOL), .in_win(in_4s));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    meas_valid_d  = 1'b0;
    meas_cycles_d = meas_cycles_q;
    class_1s_d    = class_1s_q;
    class_2s_d    = class_2s_q;
    class_4s_d    = class_4s_q;
    class_err_d   = class_err_q;
    timeout_d     = timeout_q;
    case (state_q)
      IDLE: begin
        if (rise_w) begin
          cnt_d   = '0;
          state_d = MEAS;
        end
      end
      MEAS: begin
        cnt_d = n_val;
        // An edge on the timeout cycle still counts as a (late) measurement.
        if (rise_w) begin
          meas_valid_d  = 1'b1;
          meas_cycles_d = n_val;
          class_1s_d    = in_1s;
          class_2s_d    = in_2s;
          class_4s_d    = in_4s;
          class_err_d   = ~(in_1s | in_2s | in_4s);
          cnt_d         = '0;
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = cnt_q;
          state_d   = TOUT;
        end
      end
      TOUT: begin
        if (rise_w) begin
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = MEAS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pulse_d_q     <= 1'b0;
      meas_valid_q  <= 1'b0;
      meas_cycles_q <= '0;
      class_1s_q    <= 1'b0;
      class_2s_q    <= 1'b0;
      class_4s_q    <= 1'b0;
      class_err_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pulse_d_q     <= pulse_in;
      meas_valid_q  <= meas_valid_d;
      meas_cycles_q <= meas_cycles_d;
      class_1s_q    <= class_1s_d;
      class_2s_q    <= class_2s_d;
      class_4s_q    <= class_4s_d;
      class_err_q   <= class_err_d;
      timeout_q     <= timeout_d;
    end
  end

`ifdef PULSE_PERIOD_METER_STATS_EN
  logic [STAT_W-1:0] good_count_q, good_count_d;
  logic [STAT_W-1:0] err_count_q, err_count_d;
  logic              meas_now, good_inc, err_inc;

  assign meas_now = (state_q == MEAS) && rise_w;
  assign good_inc = meas_now && (in_1s | in_2s | in_4s);
  assign err_inc  = (meas_now && !(in_1s | in_2s | in_4s)) ||
                    ((state_q == MEAS) && !rise_w && (cnt_q == TO_LAST));

  always_comb begin
    good_count_d = good_count_q;
    err_count_d  = err_count_q;
    if (good_inc) good_count_d = sat_inc(good_count_q);
    if (err_inc)  err_count_d  = sat_inc(err_count_q);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      good_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      good_count_q <= good_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign good_count = good_count_q;
  assign err_count  = err_count_q;
`else
  assign good_count = '0;
  assign err_count  = '0;
`endif

  assign meas_valid  = meas_valid_q;
  assign meas_cycles = meas_cycles_q;
  assign class_1s    = class_1s_q;
  assign class_2s    = class_2s_q;
  assign class_4s    = class_4s_q;
  assign class_err   = class_err_q;
  assign timeout     = timeout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter with CLK_HZ=100, TOL_CYCLES=2, TIMEOUT_CYCLES=500.
module tb_pulse_period_meter;
  import pulse_meter_pkg::*;

`ifdef PULSE_PERIOD_METER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        pulse_in = 1'b0;
  logic        meas_valid;
  logic [31:0] meas_cycles;
  logic        class_1s, class_2s, class_4s, class_err, timeout;
  logic [15:0] good_count, err_count;
  logic [1:0]  dbg_state;
  logic [3:0]  cls;

  int errors = 0;
  int checks = 0;
  int since  = 0;
  int mv_cnt = 0;

  pulse_period_meter #(
    .CLK_HZ(100), .TOL_CYCLES(2), .TIMEOUT_CYCLES(500)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .pulse_in(pulse_in),
    .meas_valid(meas_valid), .meas_cycles(meas_cycles),
    .class_1s(class_1s), .class_2s(class_2s), .class_4s(class_4s),
    .class_err(class_err), .timeout(timeout),
    .good_count(good_count), .err_count(err_count), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 sys_clk = ~sys_clk;
  assign cls = {class_1s, class_2s, class_4s, class_err};

  always @(negedge sys_clk) if (!rst && meas_valid) mv_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge sys_clk);
    #1;
    since++;
  endtask

  // Places the next rising edge n cycles after the previous one, held high w cycles.
  task automatic run_edge(input int n, input int w);
    while (since < n - 1) step();
    pulse_in = 1'b1;
    step();
    since = 0;
    repeat (w - 1) step();
    pulse_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pulse_in = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    mv_cnt = 0;
    since = 0;
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    checks++;
    if ({meas_valid, meas_cycles, cls, timeout, good_count, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got mv=%0b cyc=%0d cls=%b to=%0b good=%0d err=%0d required all 0",
               meas_valid, meas_cycles, cls, timeout, good_count, err_count);
    end
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE); end
    run_edge(10, 1);
    checks++;
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL first_edge_mv: got %0b required 0", meas_valid); end
    checks++;
    if (dbg_state !== MEAS) begin errors++; $display("FAIL first_edge_state: got %0d required %0d", dbg_state, MEAS); end
    repeat (20) step();
    checks++;
    if (mv_cnt !== 0 || cls !== 4'b0000 || meas_cycles !== 32'd0) begin
      errors++;
      $display("FAIL single_pulse_quiet: got mv_cnt=%0d cls=%b cyc=%0d required 0 0000 0", mv_cnt, cls, meas_cycles);
    end
  endtask

  task automatic test_1s();
    do_reset();
    run_edge(10, 1);
    for (int i = 0; i < 3; i++) begin
      run_edge(100, 1);
      checks++;
      if (meas_valid !== 1'b1 || meas_cycles !== 32'd100 || cls !== 4'b1000) begin
        errors++;
        $display("FAIL meas_1s[%0d]: got mv=%0b cyc=%0d cls=%b required 1 100 1000", i, meas_valid, meas_cycles, cls);
      end
      step();
      checks++;
      if (meas_valid !== 1'b0) begin errors++; $display("FAIL strobe_width_1s[%0d]: got %0b required 0", i, meas_valid); end
    end
    checks++;
    if (mv_cnt !== 3) begin errors++; $display("FAIL count_1s: got %0d required 3", mv_cnt); end
  endtask

  task automatic test_2s_err();
    do_reset();
    run_edge(10, 1);
    run_edge(202, 1);
    checks++;
    if (meas_cycles !== 32'd202 || cls !== 4'b0100) begin
      errors++;
      $display("FAIL meas_202: got cyc=%0d cls=%b required 202 0100", meas_cycles, cls);
    end
    run_edge(203, 1);
    checks++;
    if (meas_valid !== 1'b1 || meas_cycles !== 32'd203 || cls !== 4'b0001) begin
      errors++;
      $display("FAIL meas_203: got mv=%0b cyc=%0d cls=%b required 1 203 0001", meas_valid, meas_cycles, cls);
    end
    checks++;
    if (good_count !== (STATS ? 16'd1 : 16'd0) || err_count !== (STATS ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL stats_2s_err: got good=%0d err=%0d required %0d %0d", good_count, err_count, STATS, STATS);
    end
  endtask

  task automatic test_windows();
    int          n_tab [8] = '{98, 102, 97, 103, 198, 397, 402, 403};
    logic [3:0]  c_tab [8] = '{4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0001};
    do_reset();
    run_edge(10, 1);
    for (int i = 0; i < 8; i++) begin
      run_edge(n_tab[i], 1);
      checks++;
      if (meas_valid !== 1'b1 || meas_cycles !== 32'(n_tab[i]) || cls !== c_tab[i]) begin
        errors++;
        $display("FAIL window_%0d: got mv=%0b cyc=%0d cls=%b required 1 %0d %b",
                 n_tab[i], meas_valid, meas_cycles, cls, n_tab[i], c_tab[i]);
      end
    end
    checks++;
    if (good_count !== (STATS ? 16'd4 : 16'd0) || err_count !== (STATS ? 16'd4 : 16'd0)) begin
      errors++;
      $display("FAIL stats_windows: got good=%0d err=%0d required %0d %0d", good_count, err_count, STATS * 4, STATS * 4);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run_edge(10, 1);
    while (since < 499) step();
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %0b required 0 at cycle 499", timeout); end
    step();
    checks++;
    if (timeout !== 1'b1 || dbg_state !== TOUT) begin
      errors++;
      $display("FAIL timeout_rise: got to=%0b state=%0d required 1 %0d at cycle 500", timeout, dbg_state, TOUT);
    end
    checks++;
    if (err_count !== (STATS ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL stats_timeout: got err=%0d required %0d", err_count, STATS);
    end
    repeat (20) step();
    run_edge(since + 5, 1);
    checks++;
    if (meas_valid !== 1'b0 || timeout !== 1'b0 || dbg_state !== MEAS || mv_cnt !== 0) begin
      errors++;
      $display("FAIL timeout_recover: got mv=%0b to=%0b state=%0d mv_cnt=%0d required 0 0 %0d 0",
               meas_valid, timeout, dbg_state, mv_cnt, MEAS);
    end
    run_edge(400, 1);
    checks++;
    if (meas_valid !== 1'b1 || meas_cycles !== 32'd400 || cls !== 4'b0010 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL meas_4s: got mv=%0b cyc=%0d cls=%b to=%0b required 1 400 0010 0", meas_valid, meas_cycles, cls, timeout);
    end
    checks++;
    if (good_count !== (STATS ? 16'd1 : 16'd0) || err_count !== (STATS ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL stats_after_4s: got good=%0d err=%0d required %0d %0d", good_count, err_count, STATS, STATS);
    end
  endtask

  task automatic test_edge_at_timeout();
    do_reset();
    run_edge(10, 1);
    run_edge(500, 1);
    checks++;
    if (meas_valid !== 1'b1 || meas_cycles !== 32'd500 || cls !== 4'b0001 || timeout !== 1'b0 || dbg_state !== MEAS) begin
      errors++;
      $display("FAIL edge_at_timeout: got mv=%0b cyc=%0d cls=%b to=%0b state=%0d required 1 500 0001 0 %0d",
               meas_valid, meas_cycles, cls, timeout, dbg_state, MEAS);
    end
    run_edge(100, 1);
    checks++;
    if (meas_cycles !== 32'd100 || cls !== 4'b1000) begin
      errors++;
      $display("FAIL after_edge_at_timeout: got cyc=%0d cls=%b required 100 1000", meas_cycles, cls);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_edge(20, 10);
    for (int i = 0; i < 3; i++) run_edge(100, 10);
    step();
    checks++;
    if (mv_cnt !== 3 || meas_cycles !== 32'd100 || cls !== 4'b1000) begin
      errors++;
      $display("FAIL held_high: got mv_cnt=%0d cyc=%0d cls=%b required 3 100 1000", mv_cnt, meas_cycles, cls);
    end
  endtask

  task automatic test_rst_mid();
    int base;
    do_reset();
    run_edge(10, 1);
    run_edge(100, 1);
    while (since < 50) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({meas_valid, meas_cycles, cls, timeout, good_count, err_count} !== '0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL rst_mid_outputs: got mv=%0b cyc=%0d cls=%b to=%0b good=%0d err=%0d state=%0d required all 0",
               meas_valid, meas_cycles, cls, timeout, good_count, err_count, dbg_state);
    end
    base = mv_cnt;
    run_edge(since + 30, 1);
    checks++;
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_first_edge: got mv=%0b required 0", meas_valid); end
    run_edge(100, 1);
    checks++;
    if (meas_valid !== 1'b1 || meas_cycles !== 32'd100 || cls !== 4'b1000 || mv_cnt - base !== 0) begin
      errors++;
      $display("FAIL rst_mid_second_edge: got mv=%0b cyc=%0d cls=%b prior_strobes=%0d required 1 100 1000 0",
               meas_valid, meas_cycles, cls, mv_cnt - base);
    end
  endtask

  initial begin
    test_reset();
    test_1s();
    test_2s_err();
    test_windows();
    test_timeout();
    test_edge_at_timeout();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
